// File: rtl/stopwatch_mux_n.sv
// stopwatch_mux_n: BCD stopwatch/countdown timer with a multiplexed active-low 7-segment driver.
//
// Ports:
//   clk_in      system clock (5 MHz nominal)
//   reset_n     asynchronous active-low reset
//   start/stop/clear/lap/load   single-cycle control pulses (clear > load > stop > start)
//   dir_down    0 = count up, 1 = count down; latched on every entry to RUN
//   load_val    BCD preset, digit 0 (tenths) in [3:0]; out-of-range digits saturate
//   count_bcd   live BCD count, digit order tenths, s, 10s, min, 10min, hr, 10hr
//   seg, dp, an active-low segments {a..g}, decimal point and one-hot digit enable
//   running     high in RUN
//   done        high in DONE
//
// Optional build macro STOPWATCH_BLANK_EN enables leading-zero suppression on digits >= 2.
module stopwatch_mux_n #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 500000,
    parameter int SCAN_DIV = 2500
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  lap,
    input  logic                  dir_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [7:0]            an,
    output logic                  running,
    output logic                  done
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_MAX = SW'(SCAN_DIV - 1);
    localparam logic [2:0]    I_MAX = 3'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t              state, state_nx;
    logic [PW-1:0]       presc;
    logic [SW-1:0]       scan_cnt;
    logic [2:0]          idx;
    logic                dir_latch, freeze;
    logic [4*DIGITS-1:0] disp_reg, shown, cnt_inc, cnt_dec, load_sat, count_nx;
    logic                tick, is_zero, load_ok, enter_run, carry, borrow, all_zero;
    logic [3:0]          d, digit;
    logic [7:0]          blank;
    logic [6:0]          seg_nx;
    logic                dp_nx;

    // Largest legal value of digit i: tens-of-seconds and tens-of-minutes are base 6.
    function automatic logic [3:0] rmax(input int i);
        return (i == 2 || i == 4) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [6:0] dec7(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    assign running = (state == RUN);
    assign done    = (state == DONE);
    assign is_zero = (count_bcd == '0);
    assign tick    = (state == RUN) && (presc == P_MAX);
    assign load_ok = load && (state == IDLE || state == PAUSE);
    assign shown   = freeze ? disp_reg : count_bcd;

    // Single-cycle ripple increment/decrement plus preset saturation, one digit at a time.
    always_comb begin
        cnt_inc  = count_bcd;
        cnt_dec  = count_bcd;
        load_sat = load_val;
        carry    = 1'b1;
        borrow   = 1'b1;
        d        = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count_bcd[4*i +: 4];
            if (carry) begin
                cnt_inc[4*i +: 4] = (d >= rmax(i)) ? 4'd0 : d + 4'd1;
                carry = (d >= rmax(i));
            end
            if (borrow) begin
                cnt_dec[4*i +: 4] = (d == 4'd0) ? rmax(i) : d - 4'd1;
                borrow = (d == 4'd0);
            end
            load_sat[4*i +: 4] = (load_val[4*i +: 4] > rmax(i)) ? rmax(i) : load_val[4*i +: 4];
        end
    end

    // A counting-down RUN that has reached zero moves to DONE on the following edge;
    // resuming from PAUSE at zero in down mode skips RUN entirely.
    always_comb begin
        state_nx  = state;
        enter_run = 1'b0;
        if (clear)
            state_nx = IDLE;
        else if (load_ok)
            state_nx = state;
        else if (stop)
            state_nx = (state == RUN) ? PAUSE : state;
        else if (state == RUN && dir_latch && is_zero)
            state_nx = DONE;
        else if (start && state == IDLE) begin
            state_nx  = RUN;
            enter_run = 1'b1;
        end else if (start && state == PAUSE) begin
            state_nx  = (dir_down && is_zero) ? DONE : RUN;
            enter_run = !(dir_down && is_zero);
        end
    end

    assign count_nx = clear ? '0 : load_ok ? load_sat : tick ? (dir_latch ? cnt_dec : cnt_inc) : count_bcd;

    always_ff @(posedge clk_in or negedge reset_n)
        if (!reset_n) begin
            state     <= IDLE;
            count_bcd <= '0;
            presc     <= '0;
            dir_latch <= 1'b0;
            freeze    <= 1'b0;
            disp_reg  <= '0;
        end else begin
            state     <= state_nx;
            count_bcd <= count_nx;
            presc     <= enter_run ? '0 : (state == RUN) ? ((presc == P_MAX) ? '0 : presc + 1'b1) : presc;
            dir_latch <= enter_run ? dir_down : dir_latch;
            freeze    <= clear ? 1'b0 : lap ? !freeze : freeze;
            disp_reg  <= (lap && !freeze && !clear) ? count_bcd : disp_reg;
        end

    // Leading-zero mask: digit i is blank when it and every higher digit are zero.
    always_comb begin
        blank    = '0;
        all_zero = 1'b1;
`ifdef STOPWATCH_BLANK_EN
        for (int i = DIGITS - 1; i >= 2; i--) begin
            all_zero = all_zero && (shown[4*i +: 4] == 4'd0);
            blank[i] = all_zero;
        end
`endif
    end

    always_comb begin
        digit = '0;
        for (int i = 0; i < DIGITS; i++)
            if (idx == 3'(i))
                digit = shown[4*i +: 4];
        seg_nx = (blank[idx] || !all_zero && 1'b0) ? 7'b1111111 : dec7(digit);
        dp_nx  = blank[idx] ? 1'b1 : !(idx == 3'd1 || idx == 3'd3);
    end

    // an, seg and dp are registered together so they stay aligned one cycle behind idx.
    always_ff @(posedge clk_in or negedge reset_n)
        if (!reset_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= 8'hFF;
            seg      <= 7'b1111111;
            dp       <= 1'b1;
        end else begin
            scan_cnt <= (scan_cnt == S_MAX) ? '0 : scan_cnt + 1'b1;
            idx      <= (scan_cnt != S_MAX) ? idx : (idx == I_MAX) ? 3'd0 : idx + 3'd1;
            an       <= ~(8'd1 << idx);
            seg      <= seg_nx;
            dp       <= dp_nx;
        end
endmodule

// File: tb/tb_stopwatch_mux_n.sv
// tb_stopwatch_mux_n: directed self-checking bench for stopwatch_mux_n (DIGITS=4, TICK_DIV=10, SCAN_DIV=4).
module tb_stopwatch_mux_n;
    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] BL = 7'b1111111;
`ifdef STOPWATCH_BLANK_EN
    localparam logic [6:0] LZ = BL;
    localparam logic       LZ_DP = 1'b1;
`else
    localparam logic [6:0] LZ = S0;
    localparam logic       LZ_DP = 1'b0;
`endif

    logic        clk_in = 0, reset_n = 1;
    logic        start = 0, stop = 0, clear = 0, lap = 0, dir_down = 0, load = 0;
    logic [15:0] load_val = '0;
    logic [15:0] count_bcd;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        running, done;
    int          tests = 0, fails = 0;

    always #5 clk_in = ~clk_in;

    stopwatch_mux_n #(.DIGITS(4), .TICK_DIV(10), .SCAN_DIV(4)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
        .lap(lap), .dir_down(dir_down), .load(load), .load_val(load_val),
        .count_bcd(count_bcd), .seg(seg), .dp(dp), .an(an), .running(running), .done(done)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic pulse(input logic c, input logic ld, input logic sp, input logic st, input logic lp);
        clear = c; load = ld; stop = sp; start = st; lap = lp;
        cyc(1);
        clear = 0; load = 0; stop = 0; start = 0; lap = 0;
    endtask

    task automatic test_reset;
        #2 reset_n = 0;
        cyc(2);
        tests++; if (count_bcd !== 16'h0000) begin fails++; $display("FAIL reset_count: got %h want 0000", count_bcd); end
        tests++; if (an !== 8'hFF) begin fails++; $display("FAIL reset_an: got %h want ff", an); end
        tests++; if (seg !== BL || dp !== 1'b1) begin fails++; $display("FAIL reset_seg: got %b/%b want 1111111/1", seg, dp); end
        tests++; if (running !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_flags: got run=%b done=%b want 0/0", running, done); end
        reset_n = 1;
        cyc(1);
    endtask

    task automatic test_reset_mid_run;
        load_val = 16'h1234;
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        cyc(3);
        tests++; if (count_bcd !== 16'h1234 || running !== 1'b1) begin fails++; $display("FAIL midrun_pre: got %h run=%b want 1234 run=1", count_bcd, running); end
        #2 reset_n = 0;
        #1;
        tests++; if (count_bcd !== 16'h0000) begin fails++; $display("FAIL midrun_count: got %h want 0000", count_bcd); end
        tests++; if (an !== 8'hFF || seg !== BL || dp !== 1'b1) begin fails++; $display("FAIL midrun_disp: got an=%h seg=%b dp=%b want ff/1111111/1", an, seg, dp); end
        tests++; if (running !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midrun_flags: got run=%b done=%b want 0/0", running, done); end
        @(negedge clk_in);
        reset_n = 1;
        cyc(1);
    endtask

    task automatic test_load_saturate;
        load_val = 16'hFFFF;
        pulse(0, 1, 0, 0, 0);
        tests++; if (count_bcd !== 16'h9599) begin fails++; $display("FAIL sat_ffff: got %h want 9599", count_bcd); end
        load_val = 16'h7A6B;
        pulse(0, 1, 0, 0, 0);
        tests++; if (count_bcd !== 16'h7569) begin fails++; $display("FAIL sat_mixed: got %h want 7569", count_bcd); end
        pulse(1, 0, 0, 0, 0);
        tests++; if (count_bcd !== 16'h0000) begin fails++; $display("FAIL sat_clear: got %h want 0000", count_bcd); end
    endtask

    task automatic test_up_wrap;
        dir_down = 0;
        pulse(0, 0, 0, 1, 0);
        cyc(6000);
        tests++; if (count_bcd !== 16'h1000) begin fails++; $display("FAIL up600: got %h want 1000", count_bcd); end
        tests++; if (running !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL up600_flags: got run=%b done=%b want 1/0", running, done); end
        pulse(0, 0, 1, 0, 0);
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL up_pause: got run=%b want 0", running); end
        load_val = 16'h9599;
        pulse(0, 1, 0, 0, 0);
        tests++; if (count_bcd !== 16'h9599) begin fails++; $display("FAIL up_preset: got %h want 9599", count_bcd); end
        pulse(0, 0, 0, 1, 0);
        cyc(9);
        tests++; if (count_bcd !== 16'h9599) begin fails++; $display("FAIL up_pretick: got %h want 9599", count_bcd); end
        cyc(1);
        tests++; if (count_bcd !== 16'h0000) begin fails++; $display("FAIL up_wrap: got %h want 0000", count_bcd); end
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL up_wrap_run: got %b want 1", running); end
        pulse(1, 0, 0, 0, 0);
    endtask

    task automatic test_down_done;
        load_val = 16'h0005;
        pulse(0, 1, 0, 0, 0);
        dir_down = 1;
        pulse(0, 0, 0, 1, 0);
        dir_down = 0;
        cyc(40);
        tests++; if (count_bcd !== 16'h0001 || running !== 1'b1) begin fails++; $display("FAIL down4: got %h run=%b want 0001 run=1", count_bcd, running); end
        cyc(10);
        tests++; if (count_bcd !== 16'h0000 || done !== 1'b0) begin fails++; $display("FAIL down_zero: got %h done=%b want 0000 done=0", count_bcd, done); end
        cyc(1);
        tests++; if (done !== 1'b1 || running !== 1'b0) begin fails++; $display("FAIL down_done: got done=%b run=%b want 1/0", done, running); end
        pulse(0, 0, 0, 1, 0);
        cyc(20);
        tests++; if (done !== 1'b1 || count_bcd !== 16'h0000) begin fails++; $display("FAIL done_hold: got done=%b %h want 1 0000", done, count_bcd); end
        pulse(1, 0, 0, 0, 0);
        tests++; if (done !== 1'b0 || running !== 1'b0) begin fails++; $display("FAIL done_clear: got done=%b run=%b want 0/0", done, running); end
    endtask

    task automatic test_pause_zero_done;
        dir_down = 0;
        pulse(0, 0, 0, 1, 0);
        cyc(15);
        pulse(0, 0, 1, 0, 0);
        load_val = 16'h0000;
        pulse(0, 1, 0, 0, 0);
        tests++; if (count_bcd !== 16'h0000 || running !== 1'b0) begin fails++; $display("FAIL pz_load: got %h run=%b want 0000 run=0", count_bcd, running); end
        dir_down = 1;
        pulse(0, 0, 0, 1, 0);
        dir_down = 0;
        tests++; if (done !== 1'b1 || running !== 1'b0) begin fails++; $display("FAIL pz_done: got done=%b run=%b want 1/0", done, running); end
        pulse(1, 0, 0, 0, 0);
    endtask

    task automatic test_priority;
        dir_down = 0;
        pulse(0, 0, 0, 1, 0);
        cyc(25);
        pulse(0, 0, 1, 0, 0);
        tests++; if (count_bcd !== 16'h0002 || running !== 1'b0) begin fails++; $display("FAIL pri_pause: got %h run=%b want 0002 run=0", count_bcd, running); end
        pulse(1, 0, 0, 1, 0);
        cyc(15);
        tests++; if (count_bcd !== 16'h0000 || running !== 1'b0) begin fails++; $display("FAIL pri_clear_start: got %h run=%b want 0000 run=0", count_bcd, running); end
        pulse(0, 0, 0, 1, 0);
        cyc(10);
        pulse(0, 0, 1, 0, 0);
        load_val = 16'h0342;
        pulse(0, 1, 0, 1, 0);
        cyc(15);
        tests++; if (count_bcd !== 16'h0342 || running !== 1'b0) begin fails++; $display("FAIL pri_load_start: got %h run=%b want 0342 run=0", count_bcd, running); end
        pulse(0, 0, 0, 1, 0);
        load_val = 16'h0777;
        pulse(0, 1, 0, 0, 0);
        tests++; if (count_bcd !== 16'h0342 || running !== 1'b1) begin fails++; $display("FAIL pri_load_run: got %h run=%b want 0342 run=1", count_bcd, running); end
        pulse(0, 0, 1, 1, 0);
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL pri_stop_start: got run=%b want 0", running); end
        pulse(1, 0, 0, 0, 0);
    endtask

    task automatic test_lap;
        logic [6:0] es[4];
        logic       ed[4];
        int         seen, k;
        load_val = 16'h0123;
        pulse(0, 1, 0, 0, 0);
        dir_down = 0;
        pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 0, 0, 1);
        cyc(399);
        tests++; if (count_bcd !== 16'h0163) begin fails++; $display("FAIL lap_count: got %h want 0163", count_bcd); end
        pulse(0, 0, 1, 0, 0);
        for (int pass = 0; pass < 2; pass++) begin
            es[0] = S3; es[1] = (pass == 0) ? S2 : S6; es[2] = S1; es[3] = LZ;
            ed[0] = 1'b1; ed[1] = 1'b0; ed[2] = 1'b1; ed[3] = LZ_DP;
            seen = 0;
            for (int c = 0; c < 32; c++) begin
                cyc(1);
                k = (an == 8'hFE) ? 0 : (an == 8'hFD) ? 1 : (an == 8'hFB) ? 2 : (an == 8'hF7) ? 3 : -1;
                tests++;
                if (k < 0) begin fails++; $display("FAIL lap_an%0d: got %h want one of fe/fd/fb/f7", pass, an); end
                else if (seg !== es[k] || dp !== ed[k]) begin fails++; $display("FAIL lap_seg%0d: an=%h got %b/%b want %b/%b", pass, an, seg, dp, es[k], ed[k]); end
                else seen = seen | (1 << k);
            end
            tests++; if (seen != 15) begin fails++; $display("FAIL lap_scan%0d: digits seen %b want 1111", pass, seen[3:0]); end
            if (pass == 0) begin
                pulse(0, 0, 0, 0, 1);
                cyc(1);
            end
        end
        pulse(1, 0, 0, 0, 0);
    endtask

    task automatic test_blank;
        logic [6:0] es[4];
        logic       ed[4];
        int         seen, k;
        load_val = 16'h0050;
        pulse(0, 1, 0, 0, 0);
        cyc(1);
        es[0] = S0; es[1] = S5; es[2] = LZ; es[3] = LZ;
        ed[0] = 1'b1; ed[1] = 1'b0; ed[2] = 1'b1; ed[3] = LZ_DP;
        seen = 0;
        for (int c = 0; c < 32; c++) begin
            cyc(1);
            k = (an == 8'hFE) ? 0 : (an == 8'hFD) ? 1 : (an == 8'hFB) ? 2 : (an == 8'hF7) ? 3 : -1;
            tests++;
            if (k < 0) begin fails++; $display("FAIL blank_an: got %h want one of fe/fd/fb/f7", an); end
            else if (seg !== es[k] || dp !== ed[k]) begin fails++; $display("FAIL blank_seg: an=%h got %b/%b want %b/%b", an, seg, dp, es[k], ed[k]); end
            else seen = seen | (1 << k);
        end
        tests++; if (seen != 15) begin fails++; $display("FAIL blank_scan: digits seen %b want 1111", seen[3:0]); end
    endtask

    initial begin
        test_reset;
        test_reset_mid_run;
        test_load_saturate;
        test_up_wrap;
        test_down_done;
        test_pause_zero_done;
        test_priority;
        test_lap;
        test_blank;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
